// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_EN for early completion of divide-by-zero, signed overflow and zero multiplies.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    // Handshake: start_i is taken on a falling edge only while idle and not flushed;
    // busy_o is high from that edge until the completing edge, where done_o pulses
    // for one cycle with result_o/tag_o, which then hold until the next completion.
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_WIDTH-1:0] tag_out_q, tag_out_d;
    logic [W-1:0]     result_q, result_d;
    logic             done_q, done_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;

    logic             signed_a, signed_b, a_neg, b_neg, is_div_in;
    logic [W-1:0]     mag_a, mag_b;

    assign is_div_in = op_i[2];
    assign signed_a  = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                       (op_i == OP_DIV)  || (op_i == OP_REM);
    assign signed_b  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg     = signed_a & a_i[W-1];
    assign b_neg     = signed_b & b_i[W-1];
    assign mag_a     = a_neg ? -a_i : a_i;
    assign mag_b     = b_neg ? -b_i : b_i;

    // Multiply step: multiplier sits in the low half and shifts out as the product shifts in.
    logic [W-1:0]     mul_addend;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next;
    assign mul_addend = acc_q[0] ? mcand_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[W-1:1]};

    // Divide step: partial remainder in the high half, dividend/quotient in the low half.
    logic [W:0]       rem_sh;
    logic             q_bit;
    logic [W-1:0]     rem_new;
    logic [2*W-1:0]   div_next;
    assign rem_sh   = acc_q[2*W-1:W-1];
    assign q_bit    = rem_sh >= {1'b0, mcand_q};
    assign rem_new  = q_bit ? W'(rem_sh - {1'b0, mcand_q}) : rem_sh[W-1:0];
    assign div_next = {rem_new, acc_q[W-2:0], q_bit};

    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo_mag, rem_mag, quo, rem, fin_result;
    assign prod    = neg_lo_q ? -acc_q : acc_q;
    assign quo_mag = acc_q[W-1:0];
    assign rem_mag = acc_q[2*W-1:W];
    assign quo     = div_zero_q ? '1 : (neg_lo_q ? -quo_mag : quo_mag);
    assign rem     = neg_rem_q ? -rem_mag : rem_mag;

    always_comb begin
        fin_result = '0;
        case (op_q)
            OP_MUL:                       fin_result = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              fin_result = quo;
            OP_REM, OP_REMU:              fin_result = rem;
            default:                      fin_result = '0;
        endcase
    end

`ifdef MULDIV_FAST_EN
    logic           fast_div_zero, fast_ovf, fast_mul_zero, fast_hit;
    logic [2*W-1:0] fast_acc;
    assign fast_div_zero = is_div_in && (b_i == '0);
    assign fast_ovf      = is_div_in && !op_i[0] && (a_i == MIN_VAL) && (b_i == '1);
    assign fast_mul_zero = !is_div_in && ((a_i == '0) || (b_i == '0));
    assign fast_hit      = fast_div_zero || fast_ovf || fast_mul_zero;
    // Preload the accumulator with what the full iteration would have produced.
    always_comb begin
        fast_acc = '0;
        if (fast_div_zero)
            fast_acc = {mag_a, {W{1'b1}}};
        else if (fast_ovf)
            fast_acc = {{W{1'b0}}, mag_a};
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        tag_out_d  = tag_out_q;
        result_d   = result_q;
        done_d     = 1'b0;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        neg_lo_d   = neg_lo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    op_d       = op_i;
                    tag_d      = tag_i;
                    cnt_d      = CW'(W);
                    neg_lo_d   = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = is_div_in && (b_i == '0);
                    acc_d      = {{W{1'b0}}, (is_div_in ? mag_a : mag_b)};
                    mcand_d    = is_div_in ? mag_b : mag_a;
                    state_d    = RUN;
`ifdef MULDIV_FAST_EN
                    if (fast_hit) begin
                        acc_d   = fast_acc;
                        state_d = FINISH;
                    end
`endif
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!flush_i) begin
                    result_d  = fin_result;
                    tag_out_d = tag_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            tag_out_q  <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_lo_q   <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            tag_out_q  <= tag_out_d;
            result_q   <= result_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            neg_lo_q   <= neg_lo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign tag_o    = tag_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random RV32M operations against an arithmetic model,
// checked by a scoreboard monitor on every done pulse (result, tag and latency).
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int TW = 5;
    localparam logic [W-1:0] MIN_V = 32'h8000_0000;
    localparam logic [W-1:0] ONES  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [2:0]    op_i = '0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic          busy_o, done_o;
    logic [W-1:0]  result_o;
    logic [TW-1:0] tag_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accept_cyc = 0;
    logic [W-1:0] last_res = '0;

    logic [W-1:0]  exp_q[$];
    logic [TW-1:0] exp_tag_q[$];
    int            exp_lat_q[$];
    int            exp_t0_q[$];

    muldiv_unit #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .tag_o(tag_o)
    );

    // Clock/reset: DUT updates on the falling edge, bench samples on the rising edge.
    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        cyc++;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[W-1:0]; end
            3'd1: begin p = sa * sb; return p[2*W-1:W]; end
            3'd2: begin p = sa * ub; return p[2*W-1:W]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[2*W-1:W]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN_V && b == ONES) return a;
                return W'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return ONES;
                return W'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_V && b == ONES) return '0;
                return W'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return W'(ua % ub);
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        bit special;
        bit fast_en = 1'b0;
`ifdef MULDIV_FAST_EN
        fast_en = 1'b1;
`endif
        if (op[2]) special = (b == 0) || (!op[0] && a == MIN_V && b == ONES);
        else       special = (a == 0) || (b == 0);
        return (fast_en && special) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return ONES;
            2: return MIN_V;
            3: return W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    initial forever begin
        @(posedge clk);
        if (!rst && done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done with result 0x%h, expected no done", result_o);
            end else begin
                logic [W-1:0]  e;
                logic [TW-1:0] t;
                int            l, t0;
                e  = exp_q.pop_front();
                t  = exp_tag_q.pop_front();
                l  = exp_lat_q.pop_front();
                t0 = exp_t0_q.pop_front();
                check("result", result_o, e);
                check("tag", W'(tag_o), W'(t));
                check("latency", W'(cyc - t0), W'(l));
                last_res = e;
            end
        end
    end

    // Driver tasks.
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy_o) return;
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: busy_o stayed 1, expected 0");
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TW-1:0] tag);
        op_i = op;
        a_i = a;
        b_i = b;
        tag_i = tag;
        start_i = 1'b1;
    endtask

    task automatic wait_accept(input bit push, input bit drop);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (busy_o) begin
                if (push) begin
                    exp_q.push_back(model(op_i, a_i, b_i));
                    exp_tag_q.push_back(tag_i);
                    exp_lat_q.push_back(exp_lat(op_i, a_i, b_i));
                    exp_t0_q.push_back(cyc);
                end
                accept_cyc = cyc;
                #1;
                if (drop) start_i = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: busy_o stayed 0, expected 1");
        start_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        drive_req(op, a, b, TW'($urandom_range(0, 31)));
        wait_accept(1'b1, 1'b1);
    endtask

    initial begin
        int d0, done_at;

        // Reset with a pending request.
        drive_req(3'd0, 32'd3, 32'd4, 5'd9);
        repeat (3) begin
            @(posedge clk);
            check("rst_busy", W'(busy_o), '0);
            check("rst_done", W'(done_o), '0);
        end
        check("rst_result", result_o, '0);
        check("rst_tag", W'(tag_o), '0);
        #1 rst = 1'b0;
        wait_accept(1'b1, 1'b1);

        // Reset in the middle of an operation discards it.
        wait_idle();
        drive_req(3'd5, 32'd1000, 32'd7, 5'd3);
        wait_accept(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        check("midrst_busy", W'(busy_o), '0);
        check("midrst_result", result_o, '0);
        @(posedge clk);
        check("midrst_done", W'(done_o), '0);
        #1 rst = 1'b0;
        last_res = '0;

        // Directed cases.
        issue(3'd1, MIN_V, MIN_V);
        issue(3'd3, ONES, ONES);
        issue(3'd2, ONES, 32'd2);
        issue(3'd4, -32'sd7, 32'd2);
        issue(3'd6, -32'sd7, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        issue(3'd4, MIN_V, ONES);
        issue(3'd6, MIN_V, ONES);
        issue(3'd4, -32'sd9, 32'd0);
        issue(3'd1, 32'd0, ONES);

        // Flush during a divide.
        wait_idle();
        drive_req(3'd4, W'($urandom), W'($urandom_range(1, 1000)), 5'd17);
        wait_accept(1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        check("flush_busy", W'(busy_o), '0);
        check("flush_done", W'(done_o), '0);
        check("flush_hold", result_o, last_res);
        #1 flush_i = 1'b0;
        d0 = done_cnt;
        issue(3'd0, 32'd6, 32'd7);
        wait_idle();
        check("flush_done_count", W'(done_cnt - d0), W'(1));

        // start_i held across done, plus ignored pulses while busy.
        d0 = done_cnt;
        wait_idle();
        drive_req(3'd3, W'($urandom) | 32'd1, W'($urandom) | 32'd1, 5'd21);
        wait_accept(1'b1, 1'b0);
        a_i = W'($urandom);
        b_i = W'($urandom_range(1, 5000));
        op_i = 3'd5;
        tag_i = 5'd22;
        done_at = -1000;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (done_o) begin
                done_at = cyc;
                break;
            end
        end
        wait_accept(1'b1, 1'b1);
        check("held_accept_cycle", W'(accept_cyc), W'(done_at + 1));
        for (int i = 0; i < 8; i++) begin
            if (busy_o) start_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (3) @(posedge clk);
        check("held_done_count", W'(done_cnt - d0), W'(2));

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(op, a, b);
        end

        wait_idle();
        repeat (4) @(posedge clk);
        check("queue_empty", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execute unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core.
- Sits beside the ALU in the execute stage. Accepts one operation via a start strobe, holds busy while it iterates, then presents a registered result with a one-cycle done pulse.
- The hazard logic stalls the pipeline on busy_o; flush_i aborts an in-flight operation on branch/jump redirect.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be even and at least 8.
- TAG_WIDTH, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the core's pipeline registers.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request to begin an operation; sampled only in IDLE.
- flush_i  input  1  abort; cancels the current or requested operation.
- op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (funct3 encoding).
- a_i  input  DATA_WIDTH  operand rs1.
- b_i  input  DATA_WIDTH  operand rs2.
- tag_i  input  TAG_WIDTH  destination register index.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; result_o/tag_o valid.
- result_o  output  DATA_WIDTH  operation result.
- tag_o  output  TAG_WIDTH  tag of the completed operation.

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, result_o=0, tag_o=0, iteration counter=0. Reset mid-operation discards the operation with no done pulse.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN: on an edge with start_i=1 and flush_i=0.
  - Latch op and tag.
  - Latch operand magnitudes; sign handling is per op: signed a,b for MULH/DIV/REM; signed a, unsigned b for MULHSU; unsigned otherwise.
  - Load counter with DATA_WIDTH; busy_o=1.
- RUN: one radix-2 step per edge.
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient and remainder each DATA_WIDTH bits.
  - Counter decrements each step; at counter==1 the step executes and the FSM moves to FINISH.
- FINISH: apply sign correction; write result_o and tag_o; done_o=1 for exactly this edge; busy_o=0; FSM returns to IDLE.
  - Latency from accept edge to done edge is DATA_WIDTH+1 cycles.
- Result selection: MUL takes the low half of the product; MULH/MULHSU/MULHU take the high half; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Quotient sign is sign(a) XOR sign(b) for signed ops; remainder sign follows a.
- result_o and tag_o hold their value until the next FINISH. done_o is 0 in every other cycle.
- start_i while busy is ignored; no queueing. Upstream holds the request and stalls.
- start_i in the same cycle as a done pulse is not accepted (FSM is in FINISH); it is accepted on the following edge if still high.
- flush_i in RUN or FINISH: next edge goes to IDLE, busy_o=0, no done pulse, result_o unchanged. In IDLE, flush_i with start_i means no accept.
- Divide by zero: quotient = all ones (DIVU and DIV); remainder = a.
- Signed overflow (a = most negative, b = -1): DIV returns a; REM returns 0.
- Both special cases still take the full DATA_WIDTH+1 latency unless the optional feature is enabled.

Optional Feature:
- MULDIV_FAST_EN defined: early completion.
  - Divide by zero, signed overflow, and either multiply operand equal to zero skip RUN.
  - IDLE -> FINISH on the accept edge; done is asserted 1 cycle after accept with the same result values as the full path.
- MULDIV_FAST_EN undefined: every operation takes DATA_WIDTH+1 cycles (fixed latency, deterministic stall).

Test Plan:
- Reset with start_i=1, op MUL, a=3, b=4 -> while rst=1, busy_o=0 and done_o=0; after release, result_o=0x0000000C with done on cycle 33.
- MULH a=0x80000000, b=0x80000000 -> result_o=0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. tag_o equals tag_i for each.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000. REM same operands -> 0. Latency is 33 cycles without MULDIV_FAST_EN and 1 cycle with it.
- Start DIV, then flush_i at cycle 10 -> busy_o=0 next cycle, no done pulse, result_o keeps its previous value. A new MUL 6*7 started the following cycle -> 42.
- start_i held high across done -> the second operation is accepted one cycle after the done pulse. start_i pulses during busy are ignored: exactly two done pulses occur.
